// File: rtl/fb_scanout.sv
// fb_scanout: Avalon-MM burst reader filling a 64-bit word FIFO, unpacked to RGB888 pixels on lcd_tick.
// Colours register one clock after an enabled tick; reads throttle on FIFO space; an empty FIFO on a pixel counts as an underflow.
module fb_scanout_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push_vld,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop_rdy,
  output logic [W-1:0]               pop_dat,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_vld && (count_q != (AW+1)'(DEPTH)) && !flush;
  assign do_pop  = pop_rdy && (count_q != '0) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;
endmodule

module fb_scanout #(
  parameter int H_RES        = 800,
  parameter int V_RES        = 480,
  parameter int BURST_LENGTH = 8,
  parameter int FIFO_DEPTH   = 256,
  parameter int ADDR_WIDTH   = 29
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            burstcount,
  output logic                  read,
  input  logic                  waitrequest,
  input  logic [63:0]           readdata,
  input  logic                  readdatavalid,
  input  logic                  lcd_tick,
  input  logic                  lcd_next_frame,
  input  logic                  lcd_data_enable,
  output logic [7:0]            lcd_red,
  output logic [7:0]            lcd_green,
  output logic [7:0]            lcd_blue,
  input  logic [31:0]           front_base,
  input  logic [31:0]           back_base,
  input  logic                  swap_request,
  output logic                  swap_done,
  input  logic                  mode_16bpp,
  output logic [31:0]           underflow_count
);
  localparam int FW32 = H_RES * V_RES / 2;
  localparam int FW16 = H_RES * V_RES / 4;
  localparam int RW   = $clog2(FW32 + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FETCH, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, address_q, address_d;
  logic [RW-1:0]         remaining_q, remaining_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [7:0]            burstcount_q, burstcount_d, burst_len;
  logic                  read_q, read_d;
  logic                  mode_q, mode_d;
  logic                  pending_q, pending_d;
  logic                  swap_done_q, swap_done_d;
  logic [1:0]            sub_q, sub_d;
  logic [7:0]            red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [31:0]           underflow_q, underflow_d;
  logic [31:0]           base_sel;

  logic                  frame_start, accept, space_ok, pix_en, last_pix;
  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [63:0]           fifo_dat;
  logic [CW-1:0]         fifo_count;
  logic [15:0]           sel16;
  logic [23:0]           rgb32, rgb16, rgb;

  assign frame_start = lcd_next_frame;
  assign accept      = read_q && !waitrequest;
  assign space_ok    = (int'(fifo_count) + int'(outstanding_q) + BURST_LENGTH) <= FIFO_DEPTH;
  assign burst_len   = (32'(remaining_q) >= BURST_LENGTH) ? 8'(BURST_LENGTH) : 8'(remaining_q);
  // Only beats requested for the current frame reach the FIFO; DRAIN swallows the rest.
  assign fifo_push   = readdatavalid && (state_q == FETCH) && !frame_start;

  fb_scanout_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (frame_start),
    .push_vld (fifo_push),
    .push_dat (readdata),
    .pop_rdy  (fifo_pop),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    remaining_d   = remaining_q;
    outstanding_d = outstanding_q;
    read_d        = read_q;
    address_d     = address_q;
    burstcount_d  = burstcount_q;
    mode_d        = mode_q;
    pending_d     = pending_q | swap_request;
    swap_done_d   = 1'b0;
    base_sel      = (pending_q || swap_request) ? back_base : front_base;

    if (accept) begin
      outstanding_d = outstanding_d + CW'(burstcount_q);
      read_d        = 1'b0;
      if (state_q == FETCH) begin
        ptr_d       = ptr_q + ADDR_WIDTH'(burstcount_q);
        remaining_d = remaining_q - RW'(burstcount_q);
      end
    end
    if (readdatavalid) outstanding_d = outstanding_d - 1'b1;

    unique case (state_q)
      IDLE: ;
      DRAIN: if (outstanding_q == '0 && !read_q) state_d = FETCH;
      FETCH: begin
        if (!read_q && remaining_q != '0 && space_ok) begin
          read_d       = 1'b1;
          address_d    = ptr_q;
          burstcount_d = burst_len;
        end else if (!read_q && remaining_q == '0 && outstanding_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // A request already on the bus must stay up until accepted; its beats are drained later.
    if (frame_start) begin
      state_d     = DRAIN;
      mode_d      = mode_16bpp;
      ptr_d       = ADDR_WIDTH'(base_sel >> 3);
      remaining_d = mode_16bpp ? RW'(FW16) : RW'(FW32);
      pending_d   = 1'b0;
      swap_done_d = pending_q | swap_request;
      if (!read_q) begin
        read_d       = 1'b0;
        address_d    = address_q;
        burstcount_d = burstcount_q;
      end
    end
  end

  always_comb begin
    pix_en   = lcd_tick && lcd_data_enable;
    last_pix = mode_q ? (sub_q == 2'd3) : sub_q[0];
    unique case (sub_q)
      2'd0:    sel16 = fifo_dat[15:0];
      2'd1:    sel16 = fifo_dat[31:16];
      2'd2:    sel16 = fifo_dat[47:32];
      default: sel16 = fifo_dat[63:48];
    endcase
    rgb32 = sub_q[0] ? fifo_dat[55:32] : fifo_dat[23:0];
    rgb16 = {sel16[15:11], sel16[15:13], sel16[10:5], sel16[10:9], sel16[4:0], sel16[4:2]};
    rgb   = mode_q ? rgb16 : rgb32;

    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    sub_d       = sub_q;
    fifo_pop    = 1'b0;
    underflow_d = underflow_q;
    if (pix_en) begin
      if (fifo_empty) begin
        {red_d, green_d, blue_d} = 24'h0;
        if (underflow_q != 32'hFFFF_FFFF) underflow_d = underflow_q + 32'd1;
      end else begin
        {red_d, green_d, blue_d} = rgb;
        if (last_pix) begin
          fifo_pop = 1'b1;
          sub_d    = 2'd0;
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
    end
    if (frame_start) begin
      sub_d    = 2'd0;
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      read_q        <= 1'b0;
      address_q     <= '0;
      burstcount_q  <= '0;
      mode_q        <= 1'b0;
      pending_q     <= 1'b0;
      swap_done_q   <= 1'b0;
      sub_q         <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      underflow_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      read_q        <= read_d;
      address_q     <= address_d;
      burstcount_q  <= burstcount_d;
      mode_q        <= mode_d;
      pending_q     <= pending_d;
      swap_done_q   <= swap_done_d;
      sub_q         <= sub_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      underflow_q   <= underflow_d;
    end
  end

  assign address         = address_q;
  assign burstcount      = burstcount_q;
  assign read            = read_q;
  assign swap_done       = swap_done_q;
  assign lcd_red         = red_q;
  assign lcd_green       = green_q;
  assign lcd_blue        = blue_q;
  assign underflow_count = underflow_q;
endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on an 8x2 frame: a small Avalon memory model returns word = address
// (optionally 0xF800 at word 0x20) with configurable latency and waitrequest stalls.
module tb_fb_scanout;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic        read;
  logic        waitrequest = 1'b0;
  logic [63:0] readdata = '0;
  logic        readdatavalid = 1'b0;
  logic        lcd_tick = 1'b0;
  logic        lcd_next_frame = 1'b0;
  logic        lcd_data_enable = 1'b0;
  logic [7:0]  lcd_red, lcd_green, lcd_blue;
  logic [31:0] front_base = 32'h100;
  logic [31:0] back_base = 32'h0;
  logic        swap_request = 1'b0;
  logic        swap_done;
  logic        mode_16bpp = 1'b0;
  logic [31:0] underflow_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mem_lat = 0;
  int wr_hold = 0;
  int stall_seen = 0;
  bit ovr = 1'b0;

  int          bq_due[$];
  logic [28:0] bq_addr[$];
  logic [28:0] acc_addr[$];
  int          acc_bc[$];
  int          acc_cyc[$];

  fb_scanout #(.H_RES(8), .V_RES(2), .BURST_LENGTH(4), .FIFO_DEPTH(16), .ADDR_WIDTH(29)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .burstcount(burstcount), .read(read),
    .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
    .lcd_tick(lcd_tick), .lcd_next_frame(lcd_next_frame), .lcd_data_enable(lcd_data_enable),
    .lcd_red(lcd_red), .lcd_green(lcd_green), .lcd_blue(lcd_blue),
    .front_base(front_base), .back_base(back_base), .swap_request(swap_request),
    .swap_done(swap_done), .mode_16bpp(mode_16bpp), .underflow_count(underflow_count)
  );

  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [28:0] a);
    if (ovr && a == 29'h20) return 64'h0000_0000_0000_F800;
    return {35'b0, a};
  endfunction

  // Memory model: decides waitrequest for the coming edge, returns due beats, records accepted bursts.
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      bq_due.delete();
      bq_addr.delete();
      readdatavalid = 1'b0;
      waitrequest   = 1'b0;
    end else begin
      if (read && wr_hold > 0) begin
        waitrequest = 1'b1;
        wr_hold--;
        stall_seen++;
        chk("stall_addr", 64'(address), 64'h20);
        chk("stall_bc", 64'(burstcount), 64'd4);
      end else begin
        waitrequest = 1'b0;
      end
      if (bq_due.size() > 0 && bq_due[0] <= cyc) begin
        readdatavalid = 1'b1;
        readdata      = mem_word(bq_addr[0]);
        void'(bq_due.pop_front());
        void'(bq_addr.pop_front());
      end else begin
        readdatavalid = 1'b0;
      end
      if (read && !waitrequest) begin
        for (int i = 0; i < int'(burstcount); i++) begin
          bq_addr.push_back(address + 29'(i));
          bq_due.push_back(cyc + 1 + mem_lat);
        end
        acc_addr.push_back(address);
        acc_bc.push_back(int'(burstcount));
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic do_reset(input int lat);
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    acc_addr.delete();
    acc_bc.delete();
    acc_cyc.delete();
    mem_lat = lat;
    reset_n = 1'b1;
  endtask

  task automatic frame_pulse();
    @(negedge clock);
    lcd_next_frame = 1'b1;
    @(negedge clock);
    lcd_next_frame = 1'b0;
  endtask

  task automatic do_pixel();
    @(negedge clock);
    lcd_tick = 1'b1;
    lcd_data_enable = 1'b1;
    @(negedge clock);
    lcd_tick = 1'b0;
    lcd_data_enable = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    for (int i = 0; i < budget && acc_addr.size() < n; i++) begin
      @(negedge clock);
      #1;
    end
    chk("acc_wait", 64'(acc_addr.size() >= n), 64'd1);
  endtask

  task automatic chk_px(input string tag, input logic [23:0] exp);
    chk(tag, 64'({lcd_red, lcd_green, lcd_blue}), 64'(exp));
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clock);
    chk("rst_read", 64'(read), 64'd0);
    chk("rst_addr", 64'(address), 64'd0);
    chk("rst_bc", 64'(burstcount), 64'd0);
    chk("rst_swap_done", 64'(swap_done), 64'd0);
    chk_px("rst_colour", 24'h0);
    chk("rst_underflow", 64'(underflow_count), 64'd0);

    // 32bpp frame, zero-latency memory
    do_reset(0);
    frame_pulse();
    wait_acc(2, 100);
    repeat (20) @(negedge clock);
    chk("f32_nbursts", 64'(acc_addr.size()), 64'd2);
    chk("f32_addr0", 64'(acc_addr[0]), 64'h20);
    chk("f32_bc0", 64'(acc_bc[0]), 64'd4);
    chk("f32_addr1", 64'(acc_addr[1]), 64'h24);
    chk("f32_bc1", 64'(acc_bc[1]), 64'd4);
    for (int k = 0; k < 16; k++) begin
      do_pixel();
      chk_px($sformatf("f32_px%0d", k), (k % 2 == 0) ? 24'(32'h20 + k / 2) : 24'h0);
    end
    chk("f32_underflow", 64'(underflow_count), 64'd0);

    // 16bpp frame with 0xF800 at word 0x20
    ovr = 1'b1;
    mode_16bpp = 1'b1;
    do_reset(0);
    frame_pulse();
    wait_acc(1, 100);
    repeat (20) @(negedge clock);
    chk("f16_nbursts", 64'(acc_addr.size()), 64'd1);
    chk("f16_addr0", 64'(acc_addr[0]), 64'h20);
    chk("f16_bc0", 64'(acc_bc[0]), 64'd4);
    do_pixel(); chk_px("f16_px0", 24'hFF0000);
    do_pixel(); chk_px("f16_px1", 24'h000000);
    do_pixel(); chk_px("f16_px2", 24'h000000);
    do_pixel(); chk_px("f16_px3", 24'h000000);
    do_pixel(); chk_px("f16_px4", 24'h000408);
    ovr = 1'b0;
    mode_16bpp = 1'b0;

    // Double-buffer swap requested mid-frame
    back_base = 32'h2000;
    do_reset(0);
    frame_pulse();
    wait_acc(1, 100);
    @(negedge clock);
    swap_request = 1'b1;
    @(negedge clock);
    swap_request = 1'b0;
    repeat (30) @(negedge clock);
    chk("swp_cur_addr0", 64'(acc_addr[0]), 64'h20);
    chk("swp_cur_addr1", 64'(acc_addr[1]), 64'h24);
    chk("swp_done_early", 64'(swap_done), 64'd0);
    acc_addr.delete(); acc_bc.delete(); acc_cyc.delete();
    frame_pulse();
    chk("swp_done_pulse", 64'(swap_done), 64'd1);
    @(negedge clock);
    chk("swp_done_clear", 64'(swap_done), 64'd0);
    wait_acc(1, 100);
    chk("swp_new_addr", 64'(acc_addr[0]), 64'h400);
    repeat (30) @(negedge clock);
    acc_addr.delete(); acc_bc.delete(); acc_cyc.delete();
    frame_pulse();
    chk("swp_no_repeat", 64'(swap_done), 64'd0);
    wait_acc(1, 100);
    chk("swp_front_addr", 64'(acc_addr[0]), 64'h20);

    // waitrequest held for 10 clocks on the first burst
    do_reset(0);
    stall_seen = 0;
    wr_hold = 10;
    frame_pulse();
    wait_acc(1, 100);
    chk("wr_stall_len", 64'(stall_seen), 64'd10);
    chk("wr_addr0", 64'(acc_addr[0]), 64'h20);
    repeat (30) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      do_pixel();
      chk_px($sformatf("wr_px%0d", k), (k % 2 == 0) ? 24'(32'h20 + k / 2) : 24'h0);
    end

    // Slow memory: underflow counting and saturation
    do_reset(40);
    frame_pulse();
    for (int k = 1; k <= 3; k++) begin
      do_pixel();
      chk_px($sformatf("uf_px%0d", k), 24'h0);
      chk($sformatf("uf_cnt%0d", k), 64'(underflow_count), 64'(k));
    end
    repeat (80) @(negedge clock);
    do_pixel();
    chk_px("uf_late_px", 24'h000020);
    chk("uf_cnt_hold", 64'(underflow_count), 64'd3);
    frame_pulse();
    @(negedge clock);
    force dut.underflow_q = 32'hFFFF_FFFE;
    @(negedge clock);
    release dut.underflow_q;
    chk("sat_forced", 64'(underflow_count), 64'hFFFF_FFFE);
    do_pixel();
    chk("sat_first", 64'(underflow_count), 64'hFFFF_FFFF);
    do_pixel();
    do_pixel();
    chk("sat_hold", 64'(underflow_count), 64'hFFFF_FFFF);
    chk_px("sat_px", 24'h0);

    // New frame while one burst is still outstanding
    do_reset(40);
    frame_pulse();
    wait_acc(1, 50);
    frame_pulse();
    wait_acc(2, 200);
    chk("drn_addr1", 64'(acc_addr[1]), 64'h20);
    chk("drn_after_stale", 64'(acc_cyc[1] > acc_cyc[0] + 44), 64'd1);
    repeat (100) @(negedge clock);
    for (int w = 0; w < 8; w++) begin
      do_pixel();
      chk_px($sformatf("drn_px%0d", 2 * w), 24'(32'h20 + w));
      do_pixel();
    end
    chk("drn_underflow", 64'(underflow_count), 64'd0);

    // Asynchronous reset while a read is pending
    wr_hold = 5;
    frame_pulse();
    repeat (3) @(negedge clock);
    chk("arst_pre_read", 64'(read), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_read", 64'(read), 64'd0);
    chk("arst_addr", 64'(address), 64'd0);
    chk("arst_bc", 64'(burstcount), 64'd0);
    wr_hold = 0;
    @(negedge clock);
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
Parametrised frame-buffer scan-out engine, successor to the fixed 800x480 32bpp frame buffer reader. Avalon-MM burst read master on the HPS f2h SDRAM port that streams one frame per lcd_next_frame into an internal FIFO and presents RGB888 pixels on lcd_tick. Adds a runtime 32bpp/16bpp (RGB565) mode, double-buffer base swap at frame boundary, and an underflow counter. Sits between soc_system and the pins driven by LCD_control.

Parameters:
H_RES, 800, active pixels per line
V_RES, 480, active lines per frame
BURST_LENGTH, 8, max 64-bit beats per read burst (power of 2, <=128)
FIFO_DEPTH, 256, FIFO depth in 64-bit words (power of 2, >= 2*BURST_LENGTH)
ADDR_WIDTH, 29, Avalon word-address width (64-bit words)

Ports:
clock  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
address  out  ADDR_WIDTH  Avalon word address
burstcount  out  8  beats in current burst
read  out  1  Avalon read request
waitrequest  in  1  Avalon stall
readdata  in  64  read data beat
readdatavalid  in  1  beat valid
lcd_tick  in  1  pixel-rate enable (one clock in two)
lcd_next_frame  in  1  one-clock pulse, start of new frame
lcd_data_enable  in  1  active-pixel strobe from timing generator
lcd_red / lcd_green / lcd_blue  out  8 each  registered pixel colour
front_base  in  32  byte address of displayed buffer (8-byte aligned)
back_base  in  32  byte address for next swap
swap_request  in  1  one-clock pulse: swap to back_base at next frame
swap_done  out  1  one-clock pulse when swap applied
mode_16bpp  in  1  0 = XRGB8888, 1 = RGB565; sampled at frame start
underflow_count  out  32  saturating count of pixels emitted with FIFO empty

Behaviour:
- Reset: read=0, address=0, burstcount=0, swap_done=0, colours=0, underflow_count=0, FIFO empty, state IDLE, no swap pending.
- Frame words: FW = H_RES*V_RES/2 (32bpp) or H_RES*V_RES/4 (16bpp); latched with mode at frame start.
- States: IDLE -> (lcd_next_frame) DRAIN -> FETCH -> DONE -> (lcd_next_frame) DRAIN.
- Frame start (lcd_next_frame, any state): flush FIFO and pixel sub-index; latch mode; active base = back_base if swap pending (clear pending, swap_done=1 for one clock), else front_base; word pointer = base>>3; remaining = FW.
- DRAIN: discard readdatavalid beats until outstanding count = 0, then FETCH. Beats for the old frame never enter the FIFO.
- FETCH: assert read when FIFO free - outstanding >= BURST_LENGTH and remaining > 0; burstcount = min(BURST_LENGTH, remaining). Hold address/burstcount/read stable while waitrequest=1. On accept: pointer += burstcount, remaining -= burstcount, outstanding += burstcount. Each readdatavalid pushes to FIFO, outstanding -= 1. remaining = 0 and outstanding = 0 -> DONE.
- Swap pending set by swap_request. Repeated requests before frame start collapse to one swap using back_base sampled at frame start.
- Pixel output on clocks where lcd_tick=1 and lcd_data_enable=1. Colours register on that clock, appearing one tick after data_enable (caller delays data_enable to match).
  - 32bpp: 2 pixels/word, bits [31:0] first. R=[23:16], G=[15:8], B=[7:0].
  - 16bpp: 4 pixels/word, bits [15:0] first. R={r5,r5[4:2]}, G={g6,g6[5:4]}, B={b5,b5[4:2]}.
  - Pop FIFO after last pixel of a word.
- Underflow: FIFO empty when a pixel is needed -> colour 0, no pop, sub-index unchanged, underflow_count += 1, saturating at 0xFFFFFFFF.
- lcd_data_enable=0 on a tick: colours hold value.
- Simultaneous lcd_next_frame and readdatavalid: beat counted as outstanding-decrement and discarded.
- Simultaneous swap_request and lcd_next_frame: the swap applies this frame.
- Async reset mid-burst: all state cleared immediately. The SDRAM port is reset alongside.

Test Plan:
- H_RES=8, V_RES=2, BURST=4, FIFO=16, 32bpp, front_base=0x100, zero-wait memory returning word=address: frame pulse -> bursts at word 0x20,0x24 (count 4), 8 words, FW=8; pixels 0x20,0,0x21,0... in order; underflow_count=0.
- Same with mode_16bpp=1: FW=4, single burst 4 at 0x20; word 0x0000_0000_0000_F800 -> first pixel R=FF,G=00,B=00, next three black.
- swap_request with back_base=0x2000 mid-frame -> current frame still at 0x20; next frame pulse -> swap_done one clock, first burst at word 0x400.
- waitrequest held high 10 clocks on first burst -> address/burstcount/read stable throughout; data still correct after release.
- Memory latency 40 clocks, data_enable from reset -> first pixels 0, underflow_count increments per missed pixel, saturation checked by forcing to 0xFFFFFFFE and missing 3 pixels -> 0xFFFFFFFF.
- lcd_next_frame while 4 beats outstanding -> those beats discarded, no new read until they return, new frame pixels start from word 0x20.
